// File: rtl/vga_pkg.sv
// Shared 640x480 timing constants, decoder state encoding and pixel coordinate type.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned HS_WIDTH = 96;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned VS_WIDTH = 2;

  localparam int unsigned X_W = 10;
  localparam int unsigned Y_W = 9;

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] TRAIN  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pix_coord_t;

endpackage

// File: rtl/vga_timing_decoder_if.sv
// Video input and decoded-timing bundle between a sync source and the decoder.
interface vga_timing_decoder_if #(
  parameter int unsigned HW = 10,
  parameter int unsigned VW = 10
) ();
  import vga_pkg::*;

  logic           i_pix_stb;
  logic           i_hs;
  logic           i_vs;
  logic           i_active;
  logic [X_W-1:0] o_x;
  logic [Y_W-1:0] o_y;
  logic           o_pix_valid;
  logic [HW-1:0]  o_line_len;
  logic [VW-1:0]  o_frame_lines;
  logic           o_frame_start;
  logic           o_locked;
  logic           o_err;

  modport master (
    output i_pix_stb, i_hs, i_vs, i_active,
    input  o_x, o_y, o_pix_valid, o_line_len, o_frame_lines, o_frame_start, o_locked, o_err
  );

  modport slave (
    input  i_pix_stb, i_hs, i_vs, i_active,
    output o_x, o_y, o_pix_valid, o_line_len, o_frame_lines, o_frame_start, o_locked, o_err
  );

endinterface

// File: rtl/vga_timing_decoder_sync_edge_det.sv
// Strobe-qualified registered falling-edge detector; RST_VAL sets the idle level after reset.
module sync_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_stb,
  input  logic i_d,
  output logic o_fall_c
);

  logic q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      q <= RST_VAL;
    else if (i_stb) q <= i_d;
  end

  assign o_fall_c = q & ~i_d;

endmodule

// File: rtl/vga_timing_decoder.sv
// Receive-side timing decoder: measures line/frame periods, tracks lock and
// recovers active-pixel coordinates from hsync/vsync/data-enable.
module vga_timing_decoder #(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned HW          = 10,
  parameter int unsigned VW          = 10
) (
  input logic                 i_clk,
  input logic                 i_rst,
  vga_timing_decoder_if.slave bus
);
  import vga_pkg::*;

  localparam int unsigned GW = 4;
  localparam logic [HW-1:0]  H_MAX  = {HW{1'b1}};
  localparam logic [VW-1:0]  V_MAX  = {VW{1'b1}};
  localparam logic [X_W-1:0] X_MAX  = {X_W{1'b1}};
  localparam logic [Y_W-1:0] Y_MAX  = {Y_W{1'b1}};
  localparam logic [GW-1:0]  LOCK_N = GW'(LOCK_FRAMES);

  logic hfall_c, vfall_c, afall_c;
  logic hfall, vfall, afall;

  logic [1:0]    state, state_d;
  logic [HW-1:0] h_cnt, h_cnt_d, line_ref, line_ref_d, prev_line_ref, prev_ref_d;
  logic [VW-1:0] v_cnt, v_cnt_d, prev_lines, prev_lines_d;
  logic [GW-1:0] good_cnt, good_d;
  pix_coord_t    pos, pos_d;
  logic          hs_seen, hs_seen_d, ref_valid, ref_valid_d, frame_bad, frame_bad_d;
  logic          prev_valid, prev_valid_d;

  logic [X_W-1:0] x_d;
  logic [Y_W-1:0] y_d;
  logic [HW-1:0]  line_len_d;
  logic [VW-1:0]  frame_lines_d;
  logic           pix_valid_d, frame_start_d, locked_d, err_d;

  sync_edge_det #(.RST_VAL(1'b1)) u_hs_edge (
    .i_clk(i_clk), .i_rst(i_rst), .i_stb(bus.i_pix_stb), .i_d(bus.i_hs), .o_fall_c(hfall_c)
  );
  sync_edge_det #(.RST_VAL(1'b1)) u_vs_edge (
    .i_clk(i_clk), .i_rst(i_rst), .i_stb(bus.i_pix_stb), .i_d(bus.i_vs), .o_fall_c(vfall_c)
  );
  sync_edge_det #(.RST_VAL(1'b0)) u_act_edge (
    .i_clk(i_clk), .i_rst(i_rst), .i_stb(bus.i_pix_stb), .i_d(bus.i_active), .o_fall_c(afall_c)
  );

  assign hfall = bus.i_pix_stb & hfall_c;
  assign vfall = bus.i_pix_stb & vfall_c;
  assign afall = bus.i_pix_stb & afall_c;

  // Frame-end view: a line closing on the vsync strobe still belongs to the ending frame.
  logic          timeout, meas_ok, mismatch, end_bad, ok;
  logic [HW-1:0] line_meas, end_ref;
  logic [VW-1:0] frame_lines;
  logic [GW-1:0] good_inc;

  assign timeout     = bus.i_pix_stb & ((h_cnt == H_MAX) | (v_cnt == V_MAX));
  assign line_meas   = h_cnt + HW'(1);
  assign meas_ok     = hfall & hs_seen & ~timeout;
  assign mismatch    = meas_ok & ref_valid & (line_meas != line_ref);
  assign end_bad     = frame_bad | mismatch;
  assign end_ref     = (meas_ok & ~ref_valid) ? line_meas : line_ref;
  assign frame_lines = v_cnt + VW'(hfall);
  assign ok          = prev_valid & ~end_bad & (frame_lines == prev_lines) & (end_ref == prev_line_ref);
  assign good_inc    = good_cnt + GW'(1);

  always_comb begin
    state_d       = state;
    h_cnt_d       = h_cnt;
    v_cnt_d       = v_cnt;
    hs_seen_d     = hs_seen;
    pos_d         = pos;
    line_ref_d    = line_ref;
    ref_valid_d   = ref_valid;
    frame_bad_d   = frame_bad;
    good_d        = good_cnt;
    prev_valid_d  = prev_valid;
    prev_lines_d  = prev_lines;
    prev_ref_d    = prev_line_ref;
    x_d           = bus.o_x;
    y_d           = bus.o_y;
    line_len_d    = bus.o_line_len;
    frame_lines_d = bus.o_frame_lines;
    locked_d      = bus.o_locked;
    pix_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    err_d         = 1'b0;

    if (bus.i_pix_stb) begin
      h_cnt_d = (h_cnt == H_MAX) ? h_cnt : h_cnt + HW'(1);

      if (bus.i_active) begin
        pix_valid_d = 1'b1;
        x_d         = pos.x;
        y_d         = pos.y;
        pos_d.x     = (pos.x == X_MAX) ? pos.x : pos.x + X_W'(1);
      end
      if (afall) pos_d.y = (pos.y == Y_MAX) ? pos.y : pos.y + Y_W'(1);

      if (meas_ok) begin
        line_len_d = line_meas;
        if (!ref_valid) begin
          line_ref_d  = line_meas;
          ref_valid_d = 1'b1;
        end else if (mismatch) begin
          frame_bad_d = 1'b1;
        end
      end

      if (hfall) begin
        h_cnt_d   = '0;
        hs_seen_d = 1'b1;
        pos_d.x   = '0;
        v_cnt_d   = (v_cnt == V_MAX) ? v_cnt : v_cnt + VW'(1);
      end

      if (vfall) begin
        frame_lines_d = frame_lines;
        v_cnt_d       = '0;
        pos_d.y       = '0;
        frame_start_d = 1'b1;
        frame_bad_d   = 1'b0;
        ref_valid_d   = 1'b0;
        if (state == SEARCH) begin
          state_d      = TRAIN;
          good_d       = '0;
          prev_valid_d = 1'b0;
        end else begin
          prev_lines_d = frame_lines;
          prev_ref_d   = end_ref;
          prev_valid_d = 1'b1;
          if (state == TRAIN) begin
            good_d = ok ? good_inc : '0;
            if (ok && good_inc == LOCK_N) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else if (!ok) begin
            state_d  = TRAIN;
            good_d   = '0;
            locked_d = 1'b0;
            err_d    = 1'b1;
          end
        end
      end

      // A saturated counter means the source vanished; this overrides any frame decision.
      if (timeout) begin
        state_d   = SEARCH;
        locked_d  = 1'b0;
        hs_seen_d = 1'b0;
        err_d     = (state != SEARCH);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state             <= SEARCH;
      h_cnt             <= '0;
      v_cnt             <= '0;
      hs_seen           <= 1'b0;
      pos               <= '0;
      line_ref          <= '0;
      ref_valid         <= 1'b0;
      frame_bad         <= 1'b0;
      good_cnt          <= '0;
      prev_valid        <= 1'b0;
      prev_lines        <= '0;
      prev_line_ref     <= '0;
      bus.o_x           <= '0;
      bus.o_y           <= '0;
      bus.o_pix_valid   <= 1'b0;
      bus.o_line_len    <= '0;
      bus.o_frame_lines <= '0;
      bus.o_frame_start <= 1'b0;
      bus.o_locked      <= 1'b0;
      bus.o_err         <= 1'b0;
    end else begin
      state             <= state_d;
      h_cnt             <= h_cnt_d;
      v_cnt             <= v_cnt_d;
      hs_seen           <= hs_seen_d;
      pos               <= pos_d;
      line_ref          <= line_ref_d;
      ref_valid         <= ref_valid_d;
      frame_bad         <= frame_bad_d;
      good_cnt          <= good_d;
      prev_valid        <= prev_valid_d;
      prev_lines        <= prev_lines_d;
      prev_line_ref     <= prev_ref_d;
      bus.o_x           <= x_d;
      bus.o_y           <= y_d;
      bus.o_pix_valid   <= pix_valid_d;
      bus.o_line_len    <= line_len_d;
      bus.o_frame_lines <= frame_lines_d;
      bus.o_frame_start <= frame_start_d;
      bus.o_locked      <= locked_d;
      bus.o_err         <= err_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Scoreboard bench for vga_timing_decoder driven by a scaled-down raster
// (24 strobes/line, 14 lines/frame) so several frames fit in a short run.
module tb_vga_timing_decoder;
  import vga_pkg::*;

  localparam int unsigned HW = 10;
  localparam int unsigned VW = 10;
  localparam int T_H   = 24;
  localparam int T_HA  = 16;
  localparam int T_HS0 = 18;
  localparam int T_HS1 = 22;
  localparam int T_V   = 14;
  localparam int T_VA  = 10;
  localparam int T_VS0 = 11;
  localparam int T_VS1 = 13;

  typedef struct packed {
    logic [VW-1:0] lines;
    logic [HW-1:0] len;
    logic          locked;
    logic          err;
  } frame_exp_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  vga_timing_decoder_if #(.HW(HW), .VW(VW)) bus ();

  vga_timing_decoder #(.LOCK_FRAMES(2), .HW(HW), .VW(VW)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  pix_coord_t pix_q[$];
  frame_exp_t frm_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int err_other = 0;
  bit gap = 1'b0;

  // Source-side reference: strobes between hsync falls and hsync falls between vsync falls.
  logic prev_hs, prev_vs;
  int   cnt, hf, last_len;
  bit   seen;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    prev_hs = 1'b1; prev_vs = 1'b1;
    cnt = 0; hf = 0; last_len = 0; seen = 1'b0;
  endtask

  task automatic drive(input logic hs, input logic vs, input logic act,
                       input int x, input int y, input logic exp_lock, input logic exp_err);
    if (gap) begin
      @(posedge i_clk); #1;
      bus.i_pix_stb = 1'b0;
    end
    @(posedge i_clk); #1;
    bus.i_pix_stb = 1'b1;
    bus.i_hs = hs; bus.i_vs = vs; bus.i_active = act;
    cnt++;
    if (prev_hs && !hs) begin
      if (seen) last_len = cnt;
      cnt = 0; seen = 1'b1; hf++;
    end
    if (act) pix_q.push_back(pix_coord_t'{x: X_W'(x), y: Y_W'(y)});
    if (prev_vs && !vs) begin
      frm_q.push_back(frame_exp_t'{lines: VW'(hf), len: HW'(last_len), locked: exp_lock, err: exp_err});
      hf = 0;
    end
    prev_hs = hs; prev_vs = vs;
  endtask

  // One raster frame; long_line gets one extra blanking strobe, n_lines may be short.
  task automatic frame(input int n_lines, input int long_line, input logic exp_lock, input logic exp_err);
    for (int v = 0; v < n_lines; v++)
      for (int h = 0; h < T_H + ((v == long_line) ? 1 : 0); h++)
        drive(!(h >= T_HS0 && h < T_HS1), !(v >= T_VS0 && v < T_VS1),
              (h < T_HA && v < T_VA), h, v, exp_lock, exp_err);
  endtask

  task automatic drain(input string tag);
    @(posedge i_clk); #1;
    bus.i_pix_stb = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check({tag, "_pix_left"}, pix_q.size(), 0);
    check({tag, "_frame_left"}, frm_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_x"}, int'(bus.o_x), 0);
    check({tag, "_y"}, int'(bus.o_y), 0);
    check({tag, "_pix_valid"}, int'(bus.o_pix_valid), 0);
    check({tag, "_line_len"}, int'(bus.o_line_len), 0);
    check({tag, "_frame_lines"}, int'(bus.o_frame_lines), 0);
    check({tag, "_frame_start"}, int'(bus.o_frame_start), 0);
    check({tag, "_locked"}, int'(bus.o_locked), 0);
    check({tag, "_err"}, int'(bus.o_err), 0);
  endtask

  task automatic lock_sequence();
    frame(T_V, -1, 1'b0, 1'b0);
    frame(T_V, -1, 1'b0, 1'b0);
    frame(T_V, -1, 1'b0, 1'b0);
    frame(T_V, -1, 1'b1, 1'b0);
  endtask

  pix_coord_t pe;
  frame_exp_t fe;

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (bus.o_pix_valid) begin
        check("pix_expected", int'(pix_q.size() > 0), 1);
        if (pix_q.size() > 0) begin
          pe = pix_q.pop_front();
          check("pix_x", int'(bus.o_x), int'(pe.x));
          check("pix_y", int'(bus.o_y), int'(pe.y));
        end
      end
      if (bus.o_frame_start) begin
        check("frame_expected", int'(frm_q.size() > 0), 1);
        if (frm_q.size() > 0) begin
          fe = frm_q.pop_front();
          check("frame_lines", int'(bus.o_frame_lines), int'(fe.lines));
          check("frame_line_len", int'(bus.o_line_len), int'(fe.len));
          check("frame_locked", int'(bus.o_locked), int'(fe.locked));
          check("frame_err", int'(bus.o_err), int'(fe.err));
        end
      end else if (bus.o_err) begin
        err_other++;
      end
    end
  end

  initial begin
    bus.i_pix_stb = 1'b0; bus.i_hs = 1'b1; bus.i_vs = 1'b1; bus.i_active = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check_zero("reset");
    #2 i_rst = 1'b0;

    // Ideal source: lock after the fourth vsync, full pixel stream checked.
    lock_sequence();
    frame(T_V, -1, 1'b1, 1'b0);
    drain("A");
    check("A_line_len", int'(bus.o_line_len), 24);
    check("A_frame_lines", int'(bus.o_frame_lines), 14);
    check("A_locked", int'(bus.o_locked), 1);
    check("A_err_other", err_other, 0);

    // One 25-strobe line breaks lock at that frame's vsync, relock two frames later.
    frame(T_V, 5, 1'b0, 1'b1);
    frame(T_V, -1, 1'b0, 1'b0);
    frame(T_V, -1, 1'b1, 1'b0);
    drain("B");
    check("B_locked", int'(bus.o_locked), 1);

    // 13-line frame: reported at the following vsync with an error.
    frame(T_V - 1, -1, 1'b1, 1'b0);
    frame(T_V, -1, 1'b0, 1'b1);
    check("C_frame_lines", int'(bus.o_frame_lines), 13);
    check("C_locked", int'(bus.o_locked), 0);
    frame(T_V, -1, 1'b0, 1'b0);
    frame(T_V, -1, 1'b0, 1'b0);
    frame(T_V, -1, 1'b1, 1'b0);
    drain("C");
    check("C_err_other", err_other, 0);

    // Sync disappears: horizontal counter saturates, single error, back to search.
    for (int i = 0; i < 1100; i++) drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    drain("D_idle");
    check("D_timeout_err_pulses", err_other, 1);
    check("D_locked", int'(bus.o_locked), 0);
    lock_sequence();
    drain("D");
    check("D_relocked", int'(bus.o_locked), 1);

    // Asynchronous reset in the middle of an active line.
    for (int h = 0; h < 10; h++) drive(1'b1, 1'b1, 1'b1, h, 0, 1'b0, 1'b0);
    @(posedge i_clk); #3;
    i_rst = 1'b1;
    #1;
    check_zero("E_async");
    pix_q.delete(); frm_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk); #1;
      bus.i_pix_stb = ~bus.i_pix_stb;
      bus.i_hs = ~bus.i_hs;
    end
    #1;
    check_zero("E_held");
    bus.i_pix_stb = 1'b0; bus.i_hs = 1'b1; bus.i_vs = 1'b1; bus.i_active = 1'b0;
    model_reset();
    @(posedge i_clk); #3;
    i_rst = 1'b0;
    lock_sequence();
    drain("E");
    check("E_err_other", err_other, 1);
    check("E_locked", int'(bus.o_locked), 1);

    // Strobe on every other clock: identical measurements and lock timing.
    @(posedge i_clk); #3;
    i_rst = 1'b1;
    pix_q.delete(); frm_q.delete();
    model_reset();
    repeat (2) @(posedge i_clk);
    #3 i_rst = 1'b0;
    gap = 1'b1;
    lock_sequence();
    drain("F");
    check("F_line_len", int'(bus.o_line_len), 24);
    check("F_frame_lines", int'(bus.o_frame_lines), 14);
    check("F_locked", int'(bus.o_locked), 1);
    check("F_err_other", err_other, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_decoder.md
Name: vga_timing_decoder

Overview:
- Receive-side counterpart of the 640x480 sync generator. Samples active-low hsync/vsync and a data-enable on the pixel strobe.
- Measures line length and lines per frame, and declares lock once the timing is stable.
- Recovers the active-pixel x/y coordinates.
- Sits behind a video input or loopback path, feeding the capture, overlay and self-check logic.

Parameters:
- LOCK_FRAMES, 2, number of consecutive matching complete frames required to assert o_locked (1..15)
- HW, 10, width of the horizontal strobe counter and of o_line_len
- VW, 10, width of the line counter and of o_frame_lines

Ports:
- i_clk  in  1  base clock
- i_rst  in  1  reset; asynchronous, active-high
- i_pix_stb  in  1  pixel clock strobe; all sampling and counting happen only on cycles where this is 1
- i_hs  in  1  horizontal sync, active low
- i_vs  in  1  vertical sync, active low
- i_active  in  1  high during active pixels
- o_x  out  10  recovered active x (0..1023, saturating)
- o_y  out  9  recovered active y (0..511, saturating)
- o_pix_valid  out  1  one-clock pulse: o_x/o_y describe the pixel sampled on the previous strobe
- o_line_len  out  HW  last measured line period in strobes
- o_frame_lines  out  VW  last measured frame period in lines
- o_frame_start  out  1  one-clock pulse on a vsync falling edge
- o_locked  out  1  timing stable
- o_err  out  1  one-clock pulse on loss of lock or timeout

Behaviour:
- Async reset state:
  - All outputs 0.
  - Internal counters, flags and stored references 0.
  - hs_q = vs_q = 1.
  - State SEARCH.
- Strobe cycles only:
  - hs_q <= i_hs, vs_q <= i_vs.
  - hfall = hs_q & ~i_hs; vfall = vs_q & ~i_vs.
  - Non-strobe cycles hold all state; pulses are 0.
- Horizontal:
  - h_cnt increments per strobe, saturating at 2^HW-1.
  - On hfall, when hs_seen = 1: line_meas = h_cnt+1 and o_line_len <= line_meas.
  - On every hfall: h_cnt <= 0, hs_seen <= 1, x_cnt <= 0, v_cnt++ (saturating).
- Line-consistency check:
  - The first valid line_meas after a vfall is stored as line_ref.
  - Any later line_meas != line_ref within the frame sets frame_bad.
- Vertical, on vfall:
  - frame_lines = v_cnt, plus 1 if hfall occurs on the same strobe; o_frame_lines <= frame_lines.
  - v_cnt <= 0, y_cnt <= 0, o_frame_start pulses.
  - frame_bad and the line_ref-valid flag are cleared for the new frame.
- Pixel recovery, on a strobe with i_active = 1:
  - Next clock: o_pix_valid = 1, o_x = x_cnt, o_y = y_cnt.
  - Then x_cnt++ (saturating).
  - Falling edge of i_active (act_q = 1, i_active = 0) increments y_cnt (saturating at 511).
  - Latency: 1 clock from strobe to o_pix_valid.
- State machine, evaluated at vfall:
  - SEARCH -> TRAIN on the first vfall; good_cnt <= 0, prev_valid <= 0.
  - TRAIN, frame complete:
    - ok = prev_valid & ~frame_bad & (frame_lines == prev_lines) & (line_ref == prev_line_ref).
    - ok: good_cnt++.
    - not ok: good_cnt <= 0.
    - Always store prev_lines, prev_line_ref; prev_valid <= 1.
    - When good_cnt reaches LOCK_FRAMES: -> LOCKED, o_locked <= 1.
  - LOCKED, frame complete with ok = 0: o_err pulse, o_locked <= 0, -> TRAIN, good_cnt <= 0; the references are updated.
- Timeout:
  - h_cnt or v_cnt reaching saturation forces SEARCH and o_locked <= 0.
  - o_err pulses once, only if the block was not already in SEARCH.
  - hs_seen is cleared.
- Simultaneous events:
  - hfall and vfall on one strobe: the horizontal update is applied first, and the line counts in the ending frame.
  - Timeout and vfall on one strobe: timeout wins.
- Reset mid-frame: immediate return to reset state; no pulses are generated.

Decomposition:
- Shared package (vga_pkg):
  - 640x480 timing constants: H_ACTIVE=640, H_TOTAL=800, HS_WIDTH=96, V_ACTIVE=480, V_TOTAL=525, VS_WIDTH=2.
  - State encoding: SEARCH=2'd0, TRAIN=2'd1, LOCKED=2'd2.
  - These constants are shared with the generator and the benches.
- One sub-module, sync_edge_det:
  - Strobe-qualified registered edge detector with a reset value parameter.
  - Instantiated for hs, vs and active.

Test Plan:
1. Ideal source, 800 strobes/line, hs low 96, 525 lines/frame, vs low 2 lines, 640x480 active, LOCK_FRAMES=2 -> o_line_len=800, o_frame_lines=525; o_locked rises 1 clock after the 4th vfall; o_err never pulses.
2. Locked, then pixel stream -> exactly 640 o_pix_valid pulses per line with o_x 0..639; o_y 0..479 per frame; first pulse of each frame has x=0, y=0.
3. Locked, then one line of 801 strobes in frame N -> frame_bad; at the vfall ending frame N: o_err pulse, o_locked=0; relock 2 frames later.
4. Locked, then frame of 524 lines -> o_frame_lines=524; o_err pulse at that vfall; o_locked=0.
5. Locked, then hsync held high -> timeout when h_cnt saturates at 1023; single o_err pulse; state SEARCH; o_locked=0.
6. Asynchronous i_rst asserted mid-line with i_pix_stb toggling -> all outputs 0 within the same cycle, no o_err; after release, relock as in scenario 1.
7. Cycles with i_pix_stb=0 interleaved 1:1 with strobe cycles -> identical measurements to scenario 1.
